// File: rtl/matriz_soma_seq_if.sv
// Load/result stream bundle for the sequential matrix adder.
// The master side drives operands and consumes results.
interface matriz_soma_seq_if #(
  parameter int TAMANHO = 5,
  parameter int LARGURA = 8
);
  localparam int IDX = (TAMANHO > 1) ? $clog2(TAMANHO) : 1;

  logic               in_valid;
  logic               in_ready;
  logic [LARGURA-1:0] in_a;
  logic [LARGURA-1:0] in_b;
  logic               out_valid;
  logic               out_ready;
  logic [LARGURA-1:0] out_c;
  logic               out_carry;
  logic [IDX-1:0]     out_linha;
  logic [IDX-1:0]     out_coluna;
  logic               out_ultimo;
  logic               ocupado;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_c, out_carry, out_linha, out_coluna,
           out_ultimo, ocupado
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_c, out_carry, out_linha, out_coluna,
           out_ultimo, ocupado
  );
endinterface

// File: rtl/matriz_soma_seq.sv
// Sequential element-wise matrix adder: buffers A and B, sums one element
// per cycle into C, then streams C out row-major.
module matriz_soma_seq #(
  parameter int TAMANHO = 5,
  parameter int LARGURA = 8
) (
  input logic              clk,
  input logic              rst_n,
  matriz_soma_seq_if.slave bus
);
  localparam int IDX = (TAMANHO > 1) ? $clog2(TAMANHO) : 1;
  localparam int NE  = TAMANHO * TAMANHO;
  localparam int AW  = (NE > 1) ? $clog2(NE) : 1;
  localparam logic [IDX-1:0] ULT = IDX'(TAMANHO - 1);

  typedef enum logic [1:0] {CARGA, CALCULO, SAIDA} estado_t;

  estado_t        state_q, state_d;
  logic [IDX-1:0] linha_q, linha_d;
  logic [IDX-1:0] coluna_q, coluna_d;

  logic [LARGURA-1:0] mem_a [0:NE-1];
  logic [LARGURA-1:0] mem_b [0:NE-1];
  logic [LARGURA:0]   mem_c [0:NE-1];

  logic [AW-1:0] addr;
  logic          ultimo_pos;
  logic          advance;
  logic          wr_ab;
  logic          wr_c;
  logic          in_ready_int;
  logic          out_valid_int;
  logic [LARGURA:0] c_rd;

  assign addr       = AW'(int'(linha_q) * TAMANHO + int'(coluna_q));
  assign ultimo_pos = (linha_q == ULT) && (coluna_q == ULT);
  assign c_rd       = mem_c[addr];

  always_comb begin
    state_d       = state_q;
    linha_d       = linha_q;
    coluna_d      = coluna_q;
    in_ready_int  = 1'b0;
    out_valid_int = 1'b0;
    wr_ab         = 1'b0;
    wr_c          = 1'b0;
    advance       = 1'b0;
    case (state_q)
      CARGA: begin
        in_ready_int = 1'b1;
        if (bus.in_valid) begin
          wr_ab   = 1'b1;
          advance = 1'b1;
          if (ultimo_pos) state_d = CALCULO;
        end
      end
      CALCULO: begin
        wr_c    = 1'b1;
        advance = 1'b1;
        if (ultimo_pos) state_d = SAIDA;
      end
      SAIDA: begin
        out_valid_int = 1'b1;
        if (bus.out_ready) begin
          advance = 1'b1;
          if (ultimo_pos) state_d = CARGA;
        end
      end
      default: state_d = CARGA;
    endcase
    // Column is innermost; the final position wraps both counters to zero.
    if (advance) begin
      if (coluna_q == ULT) begin
        coluna_d = '0;
        linha_d  = (linha_q == ULT) ? '0 : linha_q + 1'b1;
      end else begin
        coluna_d = coluna_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CARGA;
      linha_q  <= '0;
      coluna_q <= '0;
    end else begin
      state_q  <= state_d;
      linha_q  <= linha_d;
      coluna_q <= coluna_d;
    end
  end

  // Buffers are never cleared; results are only exposed after a full pass.
  always_ff @(posedge clk) begin
    if (wr_ab) begin
      mem_a[addr] <= bus.in_a;
      mem_b[addr] <= bus.in_b;
    end
    if (wr_c) begin
      mem_c[addr] <= {1'b0, mem_a[addr]} + {1'b0, mem_b[addr]};
    end
  end

  assign bus.in_ready   = in_ready_int;
  assign bus.out_valid  = out_valid_int;
  assign bus.out_c      = out_valid_int ? c_rd[LARGURA-1:0] : '0;
  assign bus.out_carry  = out_valid_int ? c_rd[LARGURA] : 1'b0;
  assign bus.out_linha  = out_valid_int ? linha_q : '0;
  assign bus.out_coluna = out_valid_int ? coluna_q : '0;
  assign bus.out_ultimo = out_valid_int && ultimo_pos;
  assign bus.ocupado    = (state_q == CALCULO) || (state_q == SAIDA);
endmodule

// File: tb/tb_matriz_soma_seq.sv
// Directed bench for matriz_soma_seq: N=5 datapath plus an N=1 instance.
module tb_matriz_soma_seq;
  localparam int N  = 5;
  localparam int NE = N * N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matriz_soma_seq_if #(.TAMANHO(N), .LARGURA(8)) bus ();
  matriz_soma_seq #(.TAMANHO(N), .LARGURA(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  matriz_soma_seq_if #(.TAMANHO(1), .LARGURA(8)) bus1 ();
  matriz_soma_seq #(.TAMANHO(1), .LARGURA(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] va [NE];
  logic [7:0] vb [NE];
  logic [8:0] vc [NE];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_const(input logic [7:0] a, input logic [7:0] b, input logic [8:0] c);
    for (int k = 0; k < NE; k++) begin
      va[k] = a;
      vb[k] = b;
      vc[k] = c;
    end
  endtask

  task automatic load_pairs(input int count);
    for (int k = 0; k < count; k++) begin
      int w = 0;
      bus.in_valid = 1'b1;
      bus.in_a = va[k];
      bus.in_b = vb[k];
      while (!bus.in_ready && w < 200) begin
        @(posedge clk); #1; w++;
      end
      if (w >= 200) check("load_timeout", 32'(w), 0);
      $display("[TB] load k=%0d a=%02h b=%02h", k, va[k], vb[k]);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input int count, input bit rnd, input bit junk);
    int n = 0;
    int cyc = 0;
    bit started = 1'b0;
    while (n < count && cyc < 2000) begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (junk) begin
        bus.in_valid = 1'b1;
        bus.in_a = 8'($urandom);
        bus.in_b = 8'($urandom);
      end
      if (bus.out_valid) begin
        started = 1'b1;
        check("out_c", 32'(bus.out_c), 32'(vc[n][7:0]));
        check("out_carry", 32'(bus.out_carry), 32'(vc[n][8]));
        check("out_linha", 32'(bus.out_linha), 32'(n / N));
        check("out_coluna", 32'(bus.out_coluna), 32'(n % N));
        check("out_ultimo", 32'(bus.out_ultimo), 32'(n == NE - 1));
        if (bus.out_ready) begin
          $display("[TB] out (%0d,%0d) c=%02h carry=%0d ultimo=%0d",
                   bus.out_linha, bus.out_coluna, bus.out_c, bus.out_carry, bus.out_ultimo);
          n++;
        end
      end else if (started) begin
        check("valid_hold", 32'(bus.out_valid), 1);
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.out_ready = 1'b0;
    if (junk) bus.in_valid = 1'b0;
    check("collect_count", 32'(n), 32'(count));
    if (count == NE) begin
      check("ret_in_ready", 32'(bus.in_ready), 1);
      check("ret_out_valid", 32'(bus.out_valid), 0);
      check("ret_ocupado", 32'(bus.ocupado), 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_out_c"}, 32'(bus.out_c), 0);
    check({tag, "_out_carry"}, 32'(bus.out_carry), 0);
    check({tag, "_out_linha"}, 32'(bus.out_linha), 0);
    check({tag, "_out_coluna"}, 32'(bus.out_coluna), 0);
    check({tag, "_out_ultimo"}, 32'(bus.out_ultimo), 0);
    check({tag, "_ocupado"}, 32'(bus.ocupado), 0);
  endtask

  initial begin
    int cyc;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.out_ready = 1'b0;

    #3;
    check_reset_outputs("rst0");
    #19 rst_n = 1'b1;
    @(posedge clk); #1;

    // 4+4 everywhere, with first-result latency measured from the last load edge
    fill_const(8'd4, 8'd4, 9'h008);
    load_pairs(NE);
    check("calc_in_ready", 32'(bus.in_ready), 0);
    check("calc_ocupado", 32'(bus.ocupado), 1);
    cyc = 1;
    while (!bus.out_valid && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    check("first_valid_cycle", 32'(cyc), 32'(NE + 1));
    collect(NE, 1'b0, 1'b0);

    // Overflow corners, random stalls, in_valid held high with junk while busy
    for (int k = 0; k < NE; k++) begin
      va[k] = 8'(k);
      vb[k] = 8'(2 * k);
      vc[k] = 9'(3 * k);
    end
    va[0] = 8'd200; vb[0] = 8'd100; vc[0] = 9'h12C;
    va[1] = 8'd255; vb[1] = 8'd1;   vc[1] = 9'h100;
    va[2] = 8'd255; vb[2] = 8'd255; vc[2] = 9'h1FE;
    va[3] = 8'd0;   vb[3] = 8'd0;   vc[3] = 9'h000;
    load_pairs(NE);
    collect(NE, 1'b1, 1'b1);

    // Next load must start again at (0,0)
    for (int k = 0; k < NE; k++) begin
      va[k] = 8'(k);
      vb[k] = 8'd100;
      vc[k] = 9'(k + 100);
    end
    load_pairs(NE);
    collect(NE, 1'b1, 1'b0);

    // Reset after 12 loaded pairs
    fill_const(8'd4, 8'd4, 9'h008);
    load_pairs(12);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_load");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    fill_const(8'd3, 8'd5, 9'h008);
    load_pairs(NE);
    collect(NE, 1'b0, 1'b0);

    // Reset while presenting element 7 of an all-carry result
    fill_const(8'd200, 8'd100, 9'h12C);
    load_pairs(NE);
    collect(7, 1'b0, 1'b0);
    check("mid_out_linha", 32'(bus.out_linha), 1);
    check("mid_out_coluna", 32'(bus.out_coluna), 2);
    check("mid_out_carry", 32'(bus.out_carry), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_out");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    fill_const(8'd3, 8'd5, 9'h008);
    load_pairs(NE);
    collect(NE, 1'b1, 1'b0);

    // N=1 instance: one pair 9+7
    check("n1_in_ready", 32'(bus1.in_ready), 1);
    bus1.in_valid = 1'b1; bus1.in_a = 8'd9; bus1.in_b = 8'd7;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    $display("[TB] n1 load a=09 b=07");
    check("n1_calc_in_ready", 32'(bus1.in_ready), 0);
    check("n1_calc_valid", 32'(bus1.out_valid), 0);
    @(posedge clk); #1;
    check("n1_out_valid", 32'(bus1.out_valid), 1);
    check("n1_out_c", 32'(bus1.out_c), 32'h10);
    check("n1_out_carry", 32'(bus1.out_carry), 0);
    check("n1_out_ultimo", 32'(bus1.out_ultimo), 1);
    check("n1_out_linha", 32'(bus1.out_linha), 0);
    check("n1_out_coluna", 32'(bus1.out_coluna), 0);
    bus1.out_ready = 1'b1;
    $display("[TB] n1 out c=%02h ultimo=%0d", bus1.out_c, bus1.out_ultimo);
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    check("n1_ret_in_ready", 32'(bus1.in_ready), 1);
    check("n1_ret_out_valid", 32'(bus1.out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
